fp_align_pipe: RTL and testbench

//  Parametrised, pipelined exponent-compare and mantissa-alignment stage for the FP adder datapath.

---
 rtl/fp_align_pipe.sv | 119 +++++++++++
 tb/tb_fp_align_pipe.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fp_align_pipe.sv
// Two-stage FP adder alignment: stage 1 orders operands and saturates the exponent difference, stage 2 right-shifts the smaller mantissa with G/R/S.
// Latency 2 cycles at full throughput; a stalled output holds stable, and in_ready drops once both stages are occupied.
module fp_align_pipe #(
   parameter  int EXP_W   = 8,
   parameter  int MAN_W   = 24,
   localparam int ALN_W   = MAN_W + 3,
   localparam int SHIFT_W = $clog2(ALN_W + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               sign_a,
   input  logic [EXP_W-1:0]   exp_a,
   input  logic [MAN_W-1:0]   man_a,
   input  logic               sign_b,
   input  logic [EXP_W-1:0]   exp_b,
   input  logic [MAN_W-1:0]   man_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [EXP_W-1:0]   out_exp,
   output logic               big_sign,
   output logic [ALN_W-1:0]   big_man,
   output logic               sml_sign,
   output logic [ALN_W-1:0]   sml_man,
   output logic               swapped,
   output logic [SHIFT_W-1:0] shift
);

   logic               s1_valid;
   logic [EXP_W-1:0]   s1_exp;
   logic               s1_big_sign;
   logic [MAN_W-1:0]   s1_big_man;
   logic               s1_sml_sign;
   logic [MAN_W-1:0]   s1_sml_man;
   logic               s1_swapped;
   logic [SHIFT_W-1:0] s1_dsat;

   logic               s2_adv;
   logic               b_big;
   logic [EXP_W:0]     d;
   logic [SHIFT_W-1:0] dsat;
   logic [ALN_W-1:0]   ext;
   logic [ALN_W-1:0]   sh;
   logic [ALN_W-1:0]   lost_mask;
   logic               sticky;
   logic [ALN_W-1:0]   aligned;

   // Output register is the second stage; it frees up whenever it is empty or draining.
   assign s2_adv   = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_adv;

   always_comb begin
      b_big = (exp_b > exp_a) || ((exp_b == exp_a) && (man_b > man_a));
      if (exp_a >= exp_b)
         d = {1'b0, exp_a} - {1'b0, exp_b};
      else
         d = {1'b0, exp_b} - {1'b0, exp_a};
      dsat = (int'(d) >= ALN_W) ? SHIFT_W'(ALN_W) : SHIFT_W'(d);
   end

   // A saturated shift of ALN_W pushes every bit into the mask, leaving only the sticky bit.
   always_comb begin
      ext       = {s1_sml_man, 3'b000};
      sh        = ext >> s1_dsat;
      lost_mask = ~({ALN_W{1'b1}} << s1_dsat);
      sticky    = |(ext & lost_mask);
      aligned   = {sh[ALN_W-1:1], sh[0] | sticky};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_exp      <= '0;
         s1_big_sign <= 1'b0;
         s1_big_man  <= '0;
         s1_sml_sign <= 1'b0;
         s1_sml_man  <= '0;
         s1_swapped  <= 1'b0;
         s1_dsat     <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_swapped  <= b_big;
            s1_dsat     <= dsat;
            s1_exp      <= b_big ? exp_b  : exp_a;
            s1_big_sign <= b_big ? sign_b : sign_a;
            s1_big_man  <= b_big ? man_b  : man_a;
            s1_sml_sign <= b_big ? sign_a : sign_b;
            s1_sml_man  <= b_big ? man_a  : man_b;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_exp   <= '0;
         big_sign  <= 1'b0;
         big_man   <= '0;
         sml_sign  <= 1'b0;
         sml_man   <= '0;
         swapped   <= 1'b0;
         shift     <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_exp  <= s1_exp;
            big_sign <= s1_big_sign;
            big_man  <= {s1_big_man, 3'b000};
            sml_sign <= s1_sml_sign;
            sml_man  <= aligned;
            swapped  <= s1_swapped;
            shift    <= s1_dsat;
         end
      end
   end

endmodule

// File: tb/tb_fp_align_pipe.sv
// Directed vector table for fp_align_pipe plus hand sequences for backpressure and mid-flight reset.
module tb_fp_align_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        sign_a, sign_b;
   logic [7:0]  exp_a, exp_b;
   logic [23:0] man_a, man_b;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_exp;
   logic        big_sign, sml_sign, swapped;
   logic [26:0] big_man, sml_man;
   logic [4:0]  shift;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fp_align_pipe #(.EXP_W(8), .MAN_W(24)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .sign_a(sign_a), .exp_a(exp_a), .man_a(man_a),
      .sign_b(sign_b), .exp_b(exp_b), .man_b(man_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_exp(out_exp), .big_sign(big_sign), .big_man(big_man),
      .sml_sign(sml_sign), .sml_man(sml_man),
      .swapped(swapped), .shift(shift)
   );

   typedef struct {
      logic        sa;
      logic [7:0]  ea;
      logic [23:0] ma;
      logic        sb;
      logic [7:0]  eb;
      logic [23:0] mb;
      logic [7:0]  x_exp;
      logic        x_bs;
      logic [26:0] x_bm;
      logic        x_ss;
      logic [26:0] x_sm;
      logic        x_sw;
      logic [4:0]  x_sh;
   } vec_t;

   localparam int NV = 7;
   vec_t tbl[NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v, input logic vld);
      in_valid = vld;
      sign_a = v.sa; exp_a = v.ea; man_a = v.ma;
      sign_b = v.sb; exp_b = v.eb; man_b = v.mb;
   endtask

   task automatic check_out(input string tag, input vec_t v);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".out_exp"},   32'(out_exp),   32'(v.x_exp));
      chk({tag, ".big_sign"},  32'(big_sign),  32'(v.x_bs));
      chk({tag, ".big_man"},   32'(big_man),   32'(v.x_bm));
      chk({tag, ".sml_sign"},  32'(sml_sign),  32'(v.x_ss));
      chk({tag, ".sml_man"},   32'(sml_man),   32'(v.x_sm));
      chk({tag, ".swapped"},   32'(swapped),   32'(v.x_sw));
      chk({tag, ".shift"},     32'(shift),     32'(v.x_sh));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".out_exp"},   32'(out_exp),   32'd0);
      chk({tag, ".big_man"},   32'(big_man),   32'd0);
      chk({tag, ".sml_man"},   32'(sml_man),   32'd0);
      chk({tag, ".swapped"},   32'(swapped),   32'd0);
      chk({tag, ".shift"},     32'(shift),     32'd0);
      chk({tag, ".signs"},     32'({big_sign, sml_sign}), 32'd0);
   endtask

   initial begin
      int idx;
      int rcv;
      vec_t vz;

      //         sa  ea     ma           sb  eb     mb           exp    bs  big_man       ss  sml_man       sw  sh
      tbl[0] = '{1'b0, 8'h85, 24'hC00000, 1'b0, 8'h83, 24'h800000, 8'h85, 1'b0, 27'h6000000, 1'b0, 27'h1000000, 1'b0, 5'd2};
      tbl[1] = '{1'b1, 8'h80, 24'h800001, 1'b0, 8'h9A, 24'h800000, 8'h9A, 1'b0, 27'h4000000, 1'b1, 27'h0000001, 1'b1, 5'd26};
      tbl[2] = '{1'b0, 8'hFF, 24'h800000, 1'b1, 8'h00, 24'h000005, 8'hFF, 1'b0, 27'h4000000, 1'b1, 27'h0000001, 1'b0, 5'd27};
      tbl[3] = '{1'b0, 8'h90, 24'hA00000, 1'b1, 8'h90, 24'hB00000, 8'h90, 1'b1, 27'h5800000, 1'b0, 27'h5000000, 1'b1, 5'd0};
      tbl[4] = '{1'b0, 8'hFF, 24'h800000, 1'b0, 8'h00, 24'h000000, 8'hFF, 1'b0, 27'h4000000, 1'b0, 27'h0000000, 1'b0, 5'd27};
      tbl[5] = '{1'b0, 8'h7F, 24'h800000, 1'b1, 8'h7F, 24'h800000, 8'h7F, 1'b0, 27'h4000000, 1'b1, 27'h4000000, 1'b0, 5'd0};
      tbl[6] = '{1'b0, 8'h40, 24'h800000, 1'b0, 8'h5B, 24'hFFFFFF, 8'h5B, 1'b0, 27'h7FFFFF8, 1'b0, 27'h0000001, 1'b1, 5'd27};
      vz = tbl[0];

      rst = 1'b1; out_ready = 1'b1;
      drive(vz, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check_zero("reset");
      chk("reset.in_ready", 32'(in_ready), 32'd1);

      // Single pairs through an idle pipe: exact 2-cycle latency.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(tbl[i], 1'b1);
         #1 chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'd1);
         @(negedge clk);
         drive(tbl[i], 1'b0);
         #1 chk($sformatf("v%0d.early_valid", i), 32'(out_valid), 32'd0);
         @(negedge clk);
         #1 check_out($sformatf("v%0d", i), tbl[i]);
      end

      // Backpressure: 4 pairs offered, output stalled for 4 cycles.
      idx = 0; rcv = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         out_ready = 1'b0;
         drive(tbl[idx], idx < 4);
         #1;
         if (out_valid) check_out($sformatf("hold_c%0d", c), tbl[0]);
         if (in_valid && in_ready) idx++;
      end
      chk("bp.accepted", 32'(idx), 32'd2);
      chk("bp.in_ready_low", 32'(in_ready), 32'd0);
      for (int c = 0; c < 20 && rcv < 4; c++) begin
         @(negedge clk);
         out_ready = 1'b1;
         drive(tbl[idx < 4 ? idx : 0], idx < 4);
         #1;
         if (out_valid && out_ready) begin
            check_out($sformatf("drain%0d", rcv), tbl[rcv]);
            rcv++;
         end
         if (in_valid && in_ready) idx++;
      end
      chk("bp.received", 32'(rcv), 32'd4);
      chk("bp.sent", 32'(idx), 32'd4);
      @(negedge clk);
      drive(vz, 1'b0);
      #1 chk("bp.empty_after", 32'(out_valid), 32'd0);

      // Reset with two pairs in flight discards both.
      @(negedge clk);
      drive(tbl[1], 1'b1);
      @(negedge clk);
      drive(tbl[3], 1'b1);
      @(negedge clk);
      drive(vz, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_zero("midrst");
      chk("midrst.in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      #1 chk("midrst.no_ghost", 32'(out_valid), 32'd0);
      drive(tbl[2], 1'b1);
      @(negedge clk);
      drive(vz, 1'b0);
      #1 chk("post_rst.early_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      #1 check_out("post_rst", tbl[2]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
